ram_arbiter: RTL and testbench

Parametrised RAM-port arbiter between NCH processor-side memory requesters, a testbench override port, and the single RAM interface. It replaces the fixed two-way tbCTRL mux in the system top block. A registered round-robin grant holds each transaction until the RAM reports completion. Testbench control pre-empts all channels, and per-channel wait/load/error responses are returned.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/ram_arbiter_if.sv | 40 ++++
 rtl/rr_picker.sv | 27 ++
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, data word and RAM arbiter state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [1:0] {IDLE, GRANT, TB} arb_state_t;

  // Index width for an n-entry channel vector (at least one bit).
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters/testbench port/RAM (master) and the arbiter (slave).
interface ram_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  import cpu_types_pkg::*;

  logic [NCH-1:0]         chREN;
  logic [NCH-1:0]         chWEN;
  logic [NCH-1:0][AW-1:0] chaddr;
  logic [NCH-1:0][DW-1:0] chstore;
  logic [NCH-1:0][DW-1:0] chload;
  logic [NCH-1:0]         chwait;
  logic [NCH-1:0]         cherr;
  logic                   tbCTRL;
  logic                   tbREN;
  logic                   tbWEN;
  logic [AW-1:0]          tbaddr;
  logic [DW-1:0]          tbstore;
  logic                   ramREN;
  logic                   ramWEN;
  logic [AW-1:0]          ramaddr;
  logic [DW-1:0]          ramstore;
  logic [DW-1:0]          ramload;
  ramstate_t              ramstate;

  modport master (
    output chREN, chWEN, chaddr, chstore, tbCTRL, tbREN, tbWEN, tbaddr, tbstore,
           ramload, ramstate,
    input  chload, chwait, cherr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  chREN, chWEN, chaddr, chstore, tbCTRL, tbREN, tbWEN, tbaddr, tbstore,
           ramload, ramstate,
    output chload, chwait, cherr, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_picker.sv
// Round-robin search: first requesting channel at or after the pointer, wrapping at NCH.
module rr_picker #(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic           o_valid,
  output logic [PW-1:0]  o_idx
);

  // Scan from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    int w_cand;
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_cand = (int'(i_ptr) + k) % NCH;
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin RAM port arbiter for NCH requesters with a pre-empting testbench override.
//   state | meaning
//   IDLE  | no owner; arbitrate or hand the RAM to the testbench
//   GRANT | owner's live request drives the RAM until ACCESS/ERROR
//   TB    | testbench port drives the RAM while tbCTRL is high
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input logic           CLK,
  input logic           nRST,
  ram_arbiter_if.slave  bus
);

  localparam int PW = idx_w(NCH);

  arb_state_t      r_state;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;

  logic [NCH-1:0]  w_req;
  logic            w_pick_valid;
  logic [PW-1:0]   w_pick_idx;
  logic [PW-1:0]   w_next_ptr;
  logic            w_grant;
  logic            w_done;

  assign w_req      = bus.chREN | bus.chWEN;
  assign w_grant    = (r_state == GRANT);
  assign w_done     = w_grant && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
  assign w_next_ptr = (r_owner == PW'(NCH - 1)) ? '0 : r_owner + 1'b1;

  rr_picker #(.NCH(NCH), .PW(PW)) u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.tbCTRL) begin
            r_state <= TB;
          end else if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          // Completion wins over tbCTRL so a finished transfer is never replayed.
          if (w_done || !w_req[r_owner]) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end else if (bus.tbCTRL) begin
            r_state <= TB;
          end
        end
        TB: begin
          if (!bus.tbCTRL) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (r_state)
      GRANT: begin
        bus.ramWEN   = bus.chWEN[r_owner];
        bus.ramREN   = bus.chREN[r_owner] & ~bus.chWEN[r_owner];
        bus.ramaddr  = bus.chaddr[r_owner];
        bus.ramstore = bus.chstore[r_owner];
      end
      TB: begin
        bus.ramREN   = bus.tbREN;
        bus.ramWEN   = bus.tbWEN;
        bus.ramaddr  = bus.tbaddr;
        bus.ramstore = bus.tbstore;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.chwait = '0;
    bus.cherr  = '0;
    bus.chload = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.chload[i] = bus.ramload;
      bus.chwait[i] = w_req[i] & ~(w_done && r_owner == PW'(i));
      bus.cherr[i]  = w_grant && r_owner == PW'(i) && bus.ramstate == ERROR;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two-channel instance plus a four-channel instance.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.NCH(2), .AW(32), .DW(32)) bi ();
  ram_arbiter_if #(.NCH(4), .AW(32), .DW(32)) bi4 ();

  ram_arbiter #(.NCH(2), .AW(32), .DW(32)) dut (.CLK(clk), .nRST(nrst), .bus(bi.slave));
  ram_arbiter #(.NCH(4), .AW(32), .DW(32)) dut4 (.CLK(clk), .nRST(nrst), .bus(bi4.slave));

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic init_inputs();
    bi.chREN = '0; bi.chWEN = '0; bi.chaddr = '0; bi.chstore = '0;
    bi.tbCTRL = 1'b0; bi.tbREN = 1'b0; bi.tbWEN = 1'b0; bi.tbaddr = '0; bi.tbstore = '0;
    bi.ramload = '0; bi.ramstate = FREE;
    bi4.chREN = '0; bi4.chWEN = '0; bi4.chaddr = '0; bi4.chstore = '0;
    bi4.tbCTRL = 1'b0; bi4.tbREN = 1'b0; bi4.tbWEN = 1'b0; bi4.tbaddr = '0; bi4.tbstore = '0;
    bi4.ramload = '0; bi4.ramstate = FREE;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++; if ({bi.ramREN, bi.ramWEN} !== 2'b00) begin bad++; $display("FAIL reset_ram_en got=%b exp=00", {bi.ramREN, bi.ramWEN}); end
    total++; if (bi.ramaddr !== 32'h0) begin bad++; $display("FAIL reset_ramaddr got=%h exp=0", bi.ramaddr); end
    total++; if ({bi.chwait, bi.cherr} !== 4'b0000) begin bad++; $display("FAIL reset_wait_err got=%b exp=0000", {bi.chwait, bi.cherr}); end
    total++; if (dut.r_state !== IDLE || dut.r_rr_ptr !== 1'b0) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0/0", dut.r_state, dut.r_rr_ptr); end
    nrst = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    bi.chREN = 2'b01; bi.chaddr[0] = 32'h100; bi.ramstate = BUSY;
    #1;
    total++; if (bi.ramREN !== 1'b0) begin bad++; $display("FAIL single_latency got=%b exp=0", bi.ramREN); end
    cycle();
    #1;
    total++; if (bi.ramREN !== 1'b1 || bi.ramaddr !== 32'h100) begin bad++; $display("FAIL single_grant got=%b/%h exp=1/100", bi.ramREN, bi.ramaddr); end
    total++; if (bi.chwait !== 2'b01) begin bad++; $display("FAIL single_wait_busy got=%b exp=01", bi.chwait); end
    cycle();
    cycle();
    bi.ramstate = ACCESS; bi.ramload = 32'hCAFEF00D;
    #1;
    total++; if (bi.chwait !== 2'b00) begin bad++; $display("FAIL single_wait_done got=%b exp=00", bi.chwait); end
    total++; if (bi.chload[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL single_load got=%h exp=cafef00d", bi.chload[0]); end
    bi.chREN = 2'b00;
    cycle();
    bi.ramstate = FREE;
    #1;
    total++; if (dut.r_rr_ptr !== 1'b1 || bi.ramREN !== 1'b0) begin bad++; $display("FAIL single_rr got=%b/%b exp=1/0", dut.r_rr_ptr, bi.ramREN); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    logic [1:0]  exp_wait;
    nrst = 1'b0; #1; nrst = 1'b1;
    bi.chREN = 2'b11; bi.chaddr[0] = 32'h10; bi.chaddr[1] = 32'h20; bi.ramstate = FREE;
    cycle();
    for (int t = 0; t < 4; t++) begin
      exp_addr = (t % 2 == 0) ? 32'h10 : 32'h20;
      exp_wait = (t % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      total++; if (bi.ramaddr !== exp_addr) begin bad++; $display("FAIL rr_order t=%0d got=%h exp=%h", t, bi.ramaddr, exp_addr); end
      bi.ramstate = ACCESS;
      #1;
      total++; if (bi.chwait !== exp_wait) begin bad++; $display("FAIL rr_wait t=%0d got=%b exp=%b", t, bi.chwait, exp_wait); end
      if (t == 3) bi.chREN = 2'b00;
      cycle();
      bi.ramstate = FREE;
      #1;
      total++; if (bi.ramREN !== 1'b0) begin bad++; $display("FAIL rr_idle_gap t=%0d got=%b exp=0", t, bi.ramREN); end
      if (t < 3) cycle();
    end
    total++; if (dut.r_rr_ptr !== 1'b0) begin bad++; $display("FAIL rr_ptr_end got=%b exp=0", dut.r_rr_ptr); end
  endtask

  task automatic test_write_priority();
    bi.chREN = 2'b10; bi.chWEN = 2'b10; bi.chaddr[1] = 32'h40; bi.chstore[1] = 32'hDEADBEEF;
    cycle();
    #1;
    total++; if (bi.ramWEN !== 1'b1 || bi.ramREN !== 1'b0) begin bad++; $display("FAIL wen_prio got=%b%b exp=10", bi.ramWEN, bi.ramREN); end
    total++; if (bi.ramstore !== 32'hDEADBEEF || bi.ramaddr !== 32'h40) begin bad++; $display("FAIL wen_data got=%h/%h exp=deadbeef/40", bi.ramstore, bi.ramaddr); end
    bi.ramstate = ACCESS;
    bi.chREN = 2'b00; bi.chWEN = 2'b00;
    cycle();
    bi.ramstate = FREE;
    #1;
    total++; if (dut.r_rr_ptr !== 1'b0) begin bad++; $display("FAIL wen_rr_wrap got=%b exp=0", dut.r_rr_ptr); end
  endtask

  task automatic test_tb_preempt();
    bi.chREN = 2'b01; bi.chaddr[0] = 32'h200;
    cycle();
    bi.ramstate = BUSY;
    bi.tbCTRL = 1'b1; bi.tbWEN = 1'b1; bi.tbaddr = 32'h300; bi.tbstore = 32'h1234;
    #1;
    total++; if (bi.ramaddr !== 32'h200) begin bad++; $display("FAIL tb_delay got=%h exp=200", bi.ramaddr); end
    cycle();
    #1;
    total++; if (bi.ramaddr !== 32'h300 || bi.ramWEN !== 1'b1 || bi.ramstore !== 32'h1234) begin bad++; $display("FAIL tb_drive got=%h/%b/%h exp=300/1/1234", bi.ramaddr, bi.ramWEN, bi.ramstore); end
    total++; if (bi.chwait[0] !== 1'b1 || dut.r_rr_ptr !== 1'b0) begin bad++; $display("FAIL tb_hold got=%b/%b exp=1/0", bi.chwait[0], dut.r_rr_ptr); end
    cycle();
    bi.tbCTRL = 1'b0; bi.tbWEN = 1'b0;
    cycle();
    #1;
    total++; if (bi.ramWEN !== 1'b0 || bi.ramaddr !== 32'h0) begin bad++; $display("FAIL tb_release got=%b/%h exp=0/0", bi.ramWEN, bi.ramaddr); end
    cycle();
    #1;
    total++; if (bi.ramaddr !== 32'h200 || bi.ramREN !== 1'b1 || dut.r_rr_ptr !== 1'b0) begin bad++; $display("FAIL tb_regrant got=%h/%b/%b exp=200/1/0", bi.ramaddr, bi.ramREN, dut.r_rr_ptr); end
    bi.ramstate = ACCESS;
    bi.chREN = 2'b00;
    cycle();
    bi.ramstate = FREE;
  endtask

  task automatic test_error();
    bi.chREN = 2'b11; bi.chaddr[0] = 32'h10; bi.chaddr[1] = 32'h20;
    cycle();
    #1;
    total++; if (bi.ramaddr !== 32'h20) begin bad++; $display("FAIL err_owner got=%h exp=20", bi.ramaddr); end
    bi.ramstate = ERROR;
    #1;
    total++; if (bi.cherr !== 2'b10 || bi.chwait !== 2'b01) begin bad++; $display("FAIL err_pulse got=%b/%b exp=10/01", bi.cherr, bi.chwait); end
    bi.chREN = 2'b01;
    cycle();
    bi.ramstate = FREE;
    #1;
    total++; if (bi.cherr !== 2'b00) begin bad++; $display("FAIL err_one_cycle got=%b exp=00", bi.cherr); end
    cycle();
    #1;
    total++; if (bi.ramaddr !== 32'h10) begin bad++; $display("FAIL err_next got=%h exp=10", bi.ramaddr); end
    bi.ramstate = ACCESS;
    bi.chREN = 2'b00;
    cycle();
    bi.ramstate = FREE;
  endtask

  task automatic test_abort();
    bi.chREN = 2'b10; bi.chaddr[1] = 32'h20;
    cycle();
    bi.ramstate = BUSY;
    #1;
    total++; if (bi.ramREN !== 1'b1) begin bad++; $display("FAIL abort_grant got=%b exp=1", bi.ramREN); end
    bi.chREN = 2'b00;
    cycle();
    #1;
    total++; if (bi.ramREN !== 1'b0 || dut.r_rr_ptr !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b/%b exp=0/0", bi.ramREN, dut.r_rr_ptr); end
    bi.ramstate = FREE;
  endtask

  task automatic test_reset_mid();
    bi.chREN = 2'b01; bi.chaddr[0] = 32'h80;
    cycle();
    bi.ramstate = BUSY;
    nrst = 1'b0;
    #1;
    total++; if (bi.ramREN !== 1'b0 || bi.ramaddr !== 32'h0 || dut.r_state !== IDLE) begin bad++; $display("FAIL reset_mid got=%b/%h/%0d exp=0/0/0", bi.ramREN, bi.ramaddr, dut.r_state); end
    nrst = 1'b1;
    bi.chREN = 2'b00; bi.ramstate = FREE;
    cycle();
  endtask

  task automatic test_nch4();
    for (int i = 0; i < 4; i++) bi4.chaddr[i] = 32'h1000 + i;
    bi4.chREN = 4'b0010;
    cycle();
    #1;
    total++; if (bi4.ramaddr !== 32'h1001) begin bad++; $display("FAIL n4_first got=%h exp=1001", bi4.ramaddr); end
    bi4.ramstate = ACCESS; bi4.chREN = 4'b0000;
    cycle();
    bi4.ramstate = FREE;
    #1;
    total++; if (dut4.r_rr_ptr !== 2'd2) begin bad++; $display("FAIL n4_ptr_start got=%0d exp=2", dut4.r_rr_ptr); end
    bi4.chREN = 4'b1010;
    cycle();
    #1;
    total++; if (bi4.ramaddr !== 32'h1003) begin bad++; $display("FAIL n4_ch3 got=%h exp=1003", bi4.ramaddr); end
    bi4.ramstate = ACCESS;
    #1;
    total++; if (bi4.chwait !== 4'b0010) begin bad++; $display("FAIL n4_wait got=%b exp=0010", bi4.chwait); end
    bi4.chREN = 4'b0010;
    cycle();
    bi4.ramstate = FREE;
    cycle();
    #1;
    total++; if (bi4.ramaddr !== 32'h1001) begin bad++; $display("FAIL n4_ch1 got=%h exp=1001", bi4.ramaddr); end
    bi4.ramstate = ACCESS; bi4.chREN = 4'b0000;
    cycle();
    bi4.ramstate = FREE;
    #1;
    total++; if (dut4.r_rr_ptr !== 2'd2) begin bad++; $display("FAIL n4_ptr_end got=%0d exp=2", dut4.r_rr_ptr); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_write_priority();
    test_tb_preempt();
    test_error();
    test_abort();
    test_reset_mid();
    test_nch4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
